// File: rtl/i2c_arbiter.sv
// Two-requester round-robin arbiter in front of one shared I2C write master, with NACK retry and start timeout.
// Latency: m_start rises 2 cycles after a lone request; done/err pulse for one cycle in REPORT.
// Backpressure: requesters hold reqN until doneN; the master throttles through m_ready, bounded by BUSY_TIMEOUT.
module i2c_arbiter #(
    parameter int RETRY_MAX    = 3,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [7:0]  addr0,
    input  logic [7:0]  addr1,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        m_start,
    output logic [7:0]  m_addr,
    output logic [15:0] m_data,
    input  logic        m_ready,
    input  logic        m_error,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE,
        REPORT
    } state_t;

    localparam logic [3:0]  RETRY_LIM = 4'(RETRY_MAX);
    localparam logic [15:0] TMO_LIM   = 16'(BUSY_TIMEOUT);

    state_t      state;
    logic        gnt;        // requester owning the current transfer
    logic        last_gnt;   // requester granted by the previous completed transfer
    logic [3:0]  retry_cnt;
    logic [15:0] tmo_cnt;
    logic        pick;       // requester that would win a grant this cycle

    // Round-robin choice: on contention the requester not served last wins, otherwise whoever asks.
    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~last_gnt;
        end else begin
            pick = req1;
        end
    end

    // Transfer sequencer with registered outputs; done/err are high only while in REPORT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            gnt       <= 1'b0;
            last_gnt  <= 1'b1;
            retry_cnt <= 4'd0;
            tmo_cnt   <= 16'd0;
            m_start   <= 1'b0;
            m_addr    <= 8'd0;
            m_data    <= 16'd0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        gnt       <= pick;
                        m_addr    <= pick ? addr1 : addr0;
                        m_data    <= pick ? data1 : data0;
                        retry_cnt <= 4'd0;
                        busy      <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    m_start <= 1'b1;
                    tmo_cnt <= 16'd0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!m_ready) begin
                        m_start <= 1'b0;
                        state   <= WAIT_DONE;
                    end else if (tmo_cnt == TMO_LIM) begin
                        // Master never acknowledged the start: give up with failure.
                        m_start <= 1'b0;
                        done0   <= ~gnt;
                        done1   <= gnt;
                        err0    <= ~gnt;
                        err1    <= gnt;
                        state   <= REPORT;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                WAIT_DONE: begin
                    if (m_ready) begin
                        if (!m_error) begin
                            done0 <= ~gnt;
                            done1 <= gnt;
                            state <= REPORT;
                        end else if (retry_cnt < RETRY_LIM) begin
                            // NACK with retries left: replay the same latched address/data.
                            retry_cnt <= retry_cnt + 4'd1;
                            state     <= START;
                        end else begin
                            done0 <= ~gnt;
                            done1 <= gnt;
                            err0  <= ~gnt;
                            err1  <= gnt;
                            state <= REPORT;
                        end
                    end
                end
                REPORT: begin
                    last_gnt <= gnt;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    m_start <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a behavioural I2C master model.
// Latency: checks start latency, timeout instant and grant order against hand-computed values.
// Backpressure: master model drops m_ready for a programmable number of cycles per attempt.
module tb_i2c_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [7:0]  addr0, addr1;
    logic [15:0] data0, data1;
    logic        done0, done1, err0, err1;
    logic        m_start;
    logic [7:0]  m_addr;
    logic [15:0] m_data;
    logic        m_ready, m_error;
    logic        busy;

    i2c_arbiter #(.RETRY_MAX(3), .BUSY_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .data0(data0), .data1(data1),
        .done0(done0), .done1(done1),
        .err0(err0), .err1(err1),
        .m_start(m_start), .m_addr(m_addr), .m_data(m_data),
        .m_ready(m_ready), .m_error(m_error),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Master model controls.
    int          mst_delay  = 4;
    bit          mst_hang   = 1'b0;
    logic [15:0] mst_err_mask = 16'h0;
    int          mst_attempt = 0;
    bit          mst_busy   = 1'b0;
    int          mst_cnt    = 0;

    // Behavioural master: takes m_start, holds m_ready low for mst_delay cycles, then reports NACK per mask.
    initial begin
        m_ready = 1'b1;
        m_error = 1'b0;
        forever begin
            tick();
            if (rst) begin
                m_ready     = 1'b1;
                m_error     = 1'b0;
                mst_busy    = 1'b0;
                mst_attempt = 0;
            end else if (mst_busy) begin
                if (mst_cnt == 0) begin
                    m_error     = mst_err_mask[mst_attempt[3:0]];
                    m_ready     = 1'b1;
                    mst_attempt = mst_attempt + 1;
                    mst_busy    = 1'b0;
                end else begin
                    mst_cnt = mst_cnt - 1;
                end
            end else if (m_start && !mst_hang) begin
                m_ready  = 1'b0;
                mst_cnt  = mst_delay;
                mst_busy = 1'b1;
            end
        end
    end

    // Observation counters sampled on the falling edge.
    int   start_cnt = 0;
    int   done0_cnt = 0;
    int   done1_cnt = 0;
    int   viol_cnt  = 0;
    logic prev_start = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (m_start && !prev_start) start_cnt++;
            prev_start = m_start;
            if (done0) done0_cnt++;
            if (done1) done1_cnt++;
            if ((done0 && done1) || (err0 && !done0) || (err1 && !done1)) viol_cnt++;
        end
    end

    task automatic wait_done(input int budget, output int which, output logic err, output int cycles);
        which  = -1;
        err    = 1'b0;
        cycles = 0;
        while (which < 0 && cycles < budget) begin
            tick();
            cycles++;
            if (done0) begin
                which = 0;
                err   = err0;
            end else if (done1) begin
                which = 1;
                err   = err1;
            end
        end
    endtask

    int   which, cyc, s_start, s_d0, s_d1;
    logic e;
    int   exp_order [4] = '{0, 1, 0, 1};
    logic [7:0] exp_addr [2] = '{8'h10, 8'h20};

    initial begin
        rst = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00;
        data0 = 16'h0; data1 = 16'h0;
        tick(); tick();
        // Reset state
        check("rst_m_start", 32'(m_start), 32'd0);
        check("rst_busy",    32'(busy),    32'd0);
        check("rst_done",    32'({done1, done0}), 32'd0);
        check("rst_err",     32'({err1, err0}),   32'd0);
        check("rst_m_addr",  32'(m_addr),  32'd0);
        check("rst_m_data",  32'(m_data),  32'd0);
        rst = 1'b0;
        tick();

        // Single write with a 20-cycle master
        mst_delay = 20; mst_err_mask = 16'h0; mst_attempt = 0;
        s_start = start_cnt; s_d0 = done0_cnt;
        addr0 = 8'h39; data0 = 16'h9803; req0 = 1'b1;
        tick();
        check("lat_cycle1_m_start", 32'(m_start), 32'd0);
        check("lat_cycle1_busy",    32'(busy),    32'd1);
        tick();
        check("lat_cycle2_m_start", 32'(m_start), 32'd1);
        check("single_m_addr", 32'(m_addr), 32'h39);
        check("single_m_data", 32'(m_data), 32'h9803);
        addr0 = 8'hFF; data0 = 16'hFFFF;
        wait_done(100, which, e, cyc);
        req0 = 1'b0;
        check("single_which", 32'(which), 32'd0);
        check("single_err",   32'(e),     32'd0);
        check("single_held_addr", 32'(m_addr), 32'h39);
        check("single_held_data", 32'(m_data), 32'h9803);
        tick();
        check("single_busy_after", 32'(busy), 32'd0);
        check("single_starts", 32'(start_cnt - s_start), 32'd1);
        check("single_done0_cnt", 32'(done0_cnt - s_d0), 32'd1);

        // Contention from reset: both held high for four transfers
        rst = 1'b1;
        mst_delay = 3; mst_err_mask = 16'h0;
        addr0 = 8'h10; addr1 = 8'h20; data0 = 16'h1111; data1 = 16'h2222;
        req0 = 1'b1; req1 = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_done(100, which, e, cyc);
            check($sformatf("rr_which_%0d", i), 32'(which), 32'(exp_order[i]));
            check($sformatf("rr_err_%0d", i), 32'(e), 32'd0);
            check($sformatf("rr_addr_%0d", i), 32'(m_addr), 32'(exp_addr[exp_order[i]]));
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(); tick();

        // Two NACKs then ACK: three starts, success
        mst_delay = 2; mst_err_mask = 16'h0003; mst_attempt = 0;
        s_start = start_cnt;
        addr0 = 8'h44; data0 = 16'hA5A5; req0 = 1'b1;
        wait_done(200, which, e, cyc);
        req0 = 1'b0;
        check("retry_which", 32'(which), 32'd0);
        check("retry_err",   32'(e),     32'd0);
        check("retry_addr",  32'(m_addr), 32'h44);
        tick(); tick();
        check("retry_starts", 32'(start_cnt - s_start), 32'd3);

        // NACK on every attempt: four starts, failure
        mst_err_mask = 16'hFFFF; mst_attempt = 0;
        s_start = start_cnt;
        addr1 = 8'h55; data1 = 16'h0F0F; req1 = 1'b1;
        wait_done(200, which, e, cyc);
        req1 = 1'b0;
        check("exhaust_which", 32'(which), 32'd1);
        check("exhaust_err",   32'(e),     32'd1);
        tick(); tick();
        check("exhaust_starts", 32'(start_cnt - s_start), 32'd4);

        // Master never drops m_ready: timeout 18 cycles after grant
        mst_hang = 1'b1; mst_err_mask = 16'h0; mst_attempt = 0;
        req1 = 1'b1;
        wait_done(100, which, e, cyc);
        req1 = 1'b0;
        check("tmo_which",  32'(which), 32'd1);
        check("tmo_err",    32'(e),     32'd1);
        check("tmo_cycles", 32'(cyc),   32'd19);
        check("tmo_m_start", 32'(m_start), 32'd0);
        tick();
        check("tmo_busy_after", 32'(busy), 32'd0);
        mst_hang = 1'b0;
        tick();

        // Reset while the master is mid-transfer
        mst_delay = 30;
        addr0 = 8'h66; data0 = 16'h7777; req0 = 1'b1;
        repeat (5) tick();
        check("mid_busy_before", 32'(busy), 32'd1);
        s_d0 = done0_cnt; s_d1 = done1_cnt;
        rst = 1'b1;
        tick();
        check("mid_m_start", 32'(m_start), 32'd0);
        check("mid_busy",    32'(busy),    32'd0);
        check("mid_done",    32'({done1, done0}), 32'd0);
        check("mid_err",     32'({err1, err0}),   32'd0);
        check("mid_m_addr",  32'(m_addr),  32'd0);
        check("mid_m_data",  32'(m_data),  32'd0);
        tick();
        rst = 1'b0; req0 = 1'b0;
        repeat (40) tick();
        check("mid_no_done0", 32'(done0_cnt - s_d0), 32'd0);
        check("mid_no_done1", 32'(done1_cnt - s_d1), 32'd0);
        mst_delay = 4; mst_err_mask = 16'h0; mst_attempt = 0;
        addr1 = 8'h5A; data1 = 16'h1234; req1 = 1'b1;
        wait_done(100, which, e, cyc);
        req1 = 1'b0;
        check("post_rst_which", 32'(which), 32'd1);
        check("post_rst_err",   32'(e),     32'd0);
        check("post_rst_addr",  32'(m_addr), 32'h5A);
        check("post_rst_data",  32'(m_data), 32'h1234);
        tick(); tick();

        check("done_err_exclusive", 32'(viol_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter RETRY_MAX, default 3: additional attempts after a NACKed transfer before an error is reported (0..15).
REQ-002 Parameter BUSY_TIMEOUT, default 1023: cycles allowed for the master to drop ready after start (1..65535).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  requester N wants a transfer; held high until its done pulse.
REQ-006 addr0 / addr1  input  8  requester N 7-bit slave address, in bits [6:0].
REQ-007 data0 / data1  input  16  requester N {register, value} write word.
REQ-008 done0 / done1  output  1  one-cycle pulse when requester N's transfer is finished.
REQ-009 err0 / err1  output  1  valid with doneN; 1 = transfer failed after retries or timed out.
REQ-010 m_start  output  1  start request to the shared I2C master.
REQ-011 m_addr  output  8  slave address to the master.
REQ-012 m_data  output  16  write word to the master.
REQ-013 m_ready  input  1  master idle/finished; low while a transfer is in progress.
REQ-014 m_error  input  1  master NACK flag; sampled only when m_ready rises.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 The FSM SHALL use states IDLE, START, WAIT_BUSY, WAIT_DONE, REPORT.
REQ-017 IDLE: if any reqN is high, grant one requester, latch its addr/data into m_addr/m_data, clear the retry counter, and go to START on the next cycle.
REQ-018 Arbitration SHALL be round-robin: when both requests are high, grant the requester that was not granted last; after reset, requester 0 has priority.
REQ-019 START: drive m_start=1, clear the timeout counter, and go to WAIT_BUSY.
REQ-020 WAIT_BUSY: hold m_start=1; when m_ready=0, go to WAIT_DONE; if the timeout counter reaches BUSY_TIMEOUT, set the failure flag and go to REPORT.
REQ-021 WAIT_DONE: m_start=0; when m_ready=1, sample m_error.
REQ-022 WAIT_DONE, m_error=0: go to REPORT with failure=0.
REQ-023 WAIT_DONE, m_error=1 with retry count < RETRY_MAX: increment the retry count and go to START, keeping the same latched addr/data.
REQ-024 WAIT_DONE, m_error=1 with retry count = RETRY_MAX: go to REPORT with failure=1.
REQ-025 REPORT: pulse doneN for exactly one cycle, set errN=failure for that cycle, record the granted requester as last-granted, and return to IDLE.
REQ-026 A new grant SHALL NOT occur before the cycle after REPORT, giving a minimum 1-cycle IDLE gap between transfers.
REQ-027 Changes to addrN/dataN after the grant SHALL NOT affect m_addr/m_data until the next grant.
REQ-028 If reqN drops mid-transfer, the transfer SHALL still complete and doneN SHALL still pulse.
REQ-029 The retry counter SHALL be 4 bits and the timeout counter 16 bits; neither may wrap.
REQ-030 At most one of done0/done1 SHALL be high in any cycle; errN SHALL be 0 whenever doneN is 0.
REQ-031 With a single requester active, latency from req rising to m_start=1 SHALL be 2 cycles.

Reset
REQ-032 rst=1 SHALL force state IDLE and set m_start, done0, done1, err0, err1 and busy to 0.
REQ-033 rst=1 SHALL clear m_addr, m_data, the retry counter and the timeout counter to 0, and set last-granted to 1 so requester 0 wins first.
REQ-034 Reset asserted mid-transfer SHALL abort without any done pulse; the master is expected to be reset by the same rst.

Verification
REQ-035 Single write: req0=1, addr0=8'h39, data0=16'h9803, master ACKs after 20 cycles -> m_start high 2 cycles after req0; m_addr=8'h39, m_data=16'h9803; done0 pulses once with err0=0.
REQ-036 Contention: req0 and req1 both high from reset -> grant order 0,1,0,1 over four transfers; done0 and done1 never coincide.
REQ-037 Retry: master returns m_error=1 on the first two attempts, then 0, RETRY_MAX=3 -> exactly 3 m_start assertions; done pulses with err=0.
REQ-038 Exhausted retries: m_error=1 on every attempt, RETRY_MAX=3 -> exactly 4 m_start assertions, then doneN with errN=1.
REQ-039 Timeout: m_ready held at 1, BUSY_TIMEOUT=16 -> doneN with errN=1 about 18 cycles after grant; busy returns to 0.
REQ-040 Reset mid-transfer: rst pulsed in WAIT_DONE -> all outputs 0 the next cycle, no done pulse; the next req1 is granted normally.
